// File: rtl/vga_timing_gen_if.sv
// Raster output bundle from the VGA timing generator to the pixel renderer.
// rgb exists only when VGA_TIMING_TEST_PATTERN_EN is defined.
interface vga_timing_gen_if #(
    parameter int CW = 10
);
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          vblank;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          pix_tick;
    logic          line_start;
    logic          frame_start;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [11:0]   rgb;
`endif

    modport master (
        output hsync, vsync, de, vblank,
        output pixel_x, pixel_y,
        output pix_tick, line_start, frame_start
`ifdef VGA_TIMING_TEST_PATTERN_EN
        , output rgb
`endif
    );

    modport slave (
        input hsync, vsync, de, vblank,
        input pixel_x, pixel_y,
        input pix_tick, line_start, frame_start
`ifdef VGA_TIMING_TEST_PATTERN_EN
        , input rgb
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with clock prescaler.
// Define VGA_TIMING_TEST_PATTERN_EN to add an 8-bar colour test pattern on rgb.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 4,
    parameter int CW       = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_M1 = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HT_M1  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] VT_M1  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HA     = CW'(H_ACTIVE);
    localparam logic [CW-1:0] VA     = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [CW-1:0] nx;
    logic [CW-1:0] ny;
    logic          n_de;
    logic          n_hs;
    logic          n_vs;
    logic          n_vb;

    assign tick = enable && (div_cnt == DIV_M1);

    // Next raster position; outputs are decoded from it so they land with the coordinates.
    always_comb begin
        nx = vga.pixel_x;
        ny = vga.pixel_y;
        if (vga.pixel_x == HT_M1) begin
            nx = '0;
            ny = (vga.pixel_y == VT_M1) ? '0 : vga.pixel_y + 1'b1;
        end else begin
            nx = vga.pixel_x + 1'b1;
        end
    end

    always_comb begin
        n_de = (nx < HA) && (ny < VA);
        n_hs = (nx >= HS_BEG) && (nx < HS_END);
        n_vs = (ny >= VS_BEG) && (ny < VS_END);
        n_vb = (ny >= VA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (enable) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vga.pixel_x     <= HT_M1;
            vga.pixel_y     <= VT_M1;
            vga.de          <= 1'b0;
            vga.vblank      <= 1'b1;
            vga.hsync       <= ~HS_POL;
            vga.vsync       <= ~VS_POL;
            vga.pix_tick    <= 1'b0;
            vga.line_start  <= 1'b0;
            vga.frame_start <= 1'b0;
        end else begin
            vga.pix_tick    <= tick;
            vga.line_start  <= tick && (nx == '0);
            vga.frame_start <= tick && (nx == '0) && (ny == '0);
            if (tick) begin
                vga.pixel_x <= nx;
                vga.pixel_y <= ny;
                vga.de      <= n_de;
                vga.vblank  <= n_vb;
                vga.hsync   <= n_hs ? HS_POL : ~HS_POL;
                vga.vsync   <= n_vs ? VS_POL : ~VS_POL;
            end
        end
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam logic [CW-1:0] BAR_W = CW'(H_ACTIVE / 8);

    logic [2:0]  bar;
    logic [11:0] n_rgb;

    always_comb begin
        bar   = 3'(nx / BAR_W);
        n_rgb = n_de ? {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}} : 12'h000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vga.rgb <= 12'h000;
        end else if (tick) begin
            vga.rgb <= n_rgb;
        end
    end
`endif

endmodule
